wt_dcache_ctrl: RTL and testbench



---
 rtl/wt_dcache_ctrl_pkg.sv | 54 +++++
 rtl/wt_dcache_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_wt_dcache_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_dcache_ctrl_pkg.sv
// Shared types, widths and helpers for the write-through L1 data cache read controller.
package wt_dcache_ctrl_pkg;

  localparam int unsigned XLEN                = 64;
  localparam int unsigned PLEN                = 56;
  localparam int unsigned DCACHE_USER_WIDTH   = 1;
  localparam int unsigned DCACHE_SET_ASSOC    = 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
  localparam int unsigned DCACHE_INDEX_WIDTH  = DCACHE_CL_IDX_WIDTH + DCACHE_OFFSET_WIDTH;
  localparam int unsigned DCACHE_TAG_WIDTH    = PLEN - DCACHE_INDEX_WIDTH;
  localparam int unsigned CACHE_ID_WIDTH      = 3;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [XLEN-1:0]               data_wdata;
    logic [DCACHE_USER_WIDTH-1:0]  data_wuser;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic                         data_gnt;
    logic                         data_rvalid;
    logic [XLEN-1:0]              data_rdata;
    logic [DCACHE_USER_WIDTH-1:0] data_ruser;
  } dcache_req_o_t;

  // Single cacheable region described by base and length.
  typedef struct packed {
    logic [PLEN-1:0] cached_base;
    logic [PLEN-1:0] cached_length;
  } ariane_cfg_t;

  localparam ariane_cfg_t ArianeDefaultConfig = '{
    cached_base:   56'h0000_0000_8000_0000,
    cached_length: 56'h0000_0000_4000_0000
  };

  typedef enum logic [2:0] {
    StIdle, StRead, StMissReq, StMissWait, StKillMiss, StKillMissAck, StReplayReq, StReplayRead
  } ctrl_state_e;

  // Offset form avoids overflow of base + length at the top of the address space.
  function automatic logic is_inside_cacheable_regions(ariane_cfg_t cfg, logic [PLEN-1:0] addr);
    return (addr >= cfg.cached_base) && ((addr - cfg.cached_base) < cfg.cached_length);
  endfunction

endpackage

// File: rtl/wt_dcache_ctrl.sv
// Read controller for one load/PTW port of the write-through L1 data cache.
module wt_dcache_ctrl
  import wt_dcache_ctrl_pkg::*;
#(
  parameter int unsigned RdTxId    = 1,
  parameter ariane_cfg_t ArianeCfg = ArianeDefaultConfig
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cache_en_i,
  input  dcache_req_i_t                  req_port_i,
  output dcache_req_o_t                  req_port_o,
  output logic                           miss_req_o,
  input  logic                           miss_ack_i,
  output logic                           miss_we_o,
  output logic [XLEN-1:0]                miss_wdata_o,
  output logic [DCACHE_USER_WIDTH-1:0]   miss_wuser_o,
  output logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_o,
  output logic [PLEN-1:0]                miss_paddr_o,
  output logic                           miss_nc_o,
  output logic [2:0]                     miss_size_o,
  output logic [CACHE_ID_WIDTH-1:0]      miss_id_o,
  input  logic                           miss_replay_i,
  input  logic                           miss_rtrn_vld_i,
  input  logic                           wr_cl_vld_i,
  output logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_o,
  output logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o,
  output logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o,
  output logic                           rd_req_o,
  input  logic                           rd_ack_i,
  output logic                           rd_tag_only_o,
  input  logic [XLEN-1:0]                rd_data_i,
  input  logic [DCACHE_USER_WIDTH-1:0]   rd_user_i,
  input  logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_i,
  input  logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_i
);

  ctrl_state_e                   r_state, w_state_d;
  logic [DCACHE_TAG_WIDTH-1:0]   r_tag;
  logic [DCACHE_INDEX_WIDTH-1:0] r_idx;
  logic [1:0]                    r_size;
  logic [DCACHE_SET_ASSOC-1:0]   r_vld_bits;
  logic                          r_rd_ack;

  logic w_gnt, w_rvalid, w_latch_req, w_save_tag, w_port_idx;
  logic [DCACHE_INDEX_WIDTH-1:0] w_idx;
  logic w_unused;

  // Write-side request fields are not used by a read port.
  assign w_unused = ^{req_port_i.data_wdata, req_port_i.data_wuser, req_port_i.data_we,
                      req_port_i.data_be};

  // Next state and handshake decode; kill always wins over other same-cycle events.
  always_comb begin
    w_state_d   = r_state;
    w_gnt       = 1'b0;
    w_rvalid    = 1'b0;
    w_latch_req = 1'b0;
    w_save_tag  = 1'b0;
    w_port_idx  = 1'b0;
    rd_req_o    = 1'b0;
    miss_req_o  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_port_idx = 1'b1;
        if (req_port_i.data_req) begin
          rd_req_o = 1'b1;
          if (rd_ack_i) begin
            w_gnt       = 1'b1;
            w_latch_req = 1'b1;
            w_state_d   = StRead;
          end
        end
      end
      StRead, StReplayRead: begin
        if (req_port_i.kill_req) begin
          w_rvalid  = 1'b1;
          w_state_d = StIdle;
        end else if (req_port_i.tag_valid || r_state == StReplayRead) begin
          w_save_tag = (r_state == StRead);
          // Array output is stale if a refill collided or the read was never acked.
          if (wr_cl_vld_i || !r_rd_ack) begin
            w_state_d = StReplayReq;
          end else if (|rd_hit_oh_i && cache_en_i) begin
            w_rvalid   = 1'b1;
            w_state_d  = StIdle;
            w_port_idx = 1'b1;
            if (req_port_i.data_req) begin
              rd_req_o = 1'b1;
              if (rd_ack_i) begin
                w_gnt       = 1'b1;
                w_latch_req = 1'b1;
                w_state_d   = StRead;
              end
            end
          end else begin
            w_state_d = StMissReq;
          end
        end
      end
      StMissReq: begin
        miss_req_o = 1'b1;
        if (req_port_i.kill_req) begin
          w_rvalid  = 1'b1;
          w_state_d = miss_ack_i ? StIdle : StKillMissAck;
        end else if (miss_replay_i) begin
          w_state_d = StReplayReq;
        end else if (miss_ack_i) begin
          w_state_d = StMissWait;
        end
      end
      StMissWait: begin
        if (req_port_i.kill_req) begin
          w_rvalid  = 1'b1;
          w_state_d = miss_rtrn_vld_i ? StIdle : StKillMiss;
        end else if (miss_rtrn_vld_i) begin
          w_rvalid  = 1'b1;
          w_state_d = StIdle;
        end
      end
      StReplayReq: begin
        rd_req_o = 1'b1;
        if (req_port_i.kill_req) begin
          w_rvalid  = 1'b1;
          w_state_d = StIdle;
        end else if (rd_ack_i) begin
          w_state_d = StReplayRead;
        end
      end
      // The killed miss is still owned by the miss unit; wait for it to drain.
      StKillMissAck: begin
        miss_req_o = 1'b1;
        if (miss_replay_i) begin
          w_state_d = StIdle;
        end else if (miss_ack_i) begin
          w_state_d = StKillMiss;
        end
      end
      StKillMiss: begin
        if (miss_rtrn_vld_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath latches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_tag      <= '0;
      r_idx      <= '0;
      r_size     <= '0;
      r_vld_bits <= '0;
      r_rd_ack   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_rd_ack <= rd_ack_i;
      if (w_latch_req) begin
        r_idx  <= req_port_i.address_index;
        r_size <= req_port_i.data_size;
      end
      if (w_save_tag) begin
        r_tag      <= req_port_i.address_tag;
        r_vld_bits <= rd_vld_bits_i;
      end
    end
  end

  assign w_idx    = w_port_idx ? req_port_i.address_index : r_idx;
  assign rd_idx_o = w_idx[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
  assign rd_off_o = w_idx[DCACHE_OFFSET_WIDTH-1:0];
  assign rd_tag_o = w_save_tag ? req_port_i.address_tag : r_tag;

  assign rd_tag_only_o   = 1'b0;
  assign miss_we_o       = 1'b0;
  assign miss_wdata_o    = '0;
  assign miss_wuser_o    = '0;
  assign miss_vld_bits_o = r_vld_bits;
  assign miss_paddr_o    = {r_tag, r_idx};
  assign miss_nc_o       = !cache_en_i || !is_inside_cacheable_regions(ArianeCfg, miss_paddr_o);
  assign miss_size_o     = {1'b0, r_size};
  assign miss_id_o       = CACHE_ID_WIDTH'(RdTxId);

  assign req_port_o = '{
    data_gnt:    w_gnt,
    data_rvalid: w_rvalid,
    data_rdata:  rd_data_i,
    data_ruser:  rd_user_i
  };

endmodule

// File: tb/tb_wt_dcache_ctrl.sv
// Self-checking bench for wt_dcache_ctrl: scenario tasks plus an rvalid scoreboard.
module tb_wt_dcache_ctrl;
  import wt_dcache_ctrl_pkg::*;

  localparam logic [DCACHE_TAG_WIDTH-1:0] TagC  = 44'h80000; // paddr 0x8000_0xxx, cacheable
  localparam logic [DCACHE_TAG_WIDTH-1:0] TagIo = 44'h00010; // paddr 0x1_0xxx, outside region

  logic clk, rst_ni, cache_en, miss_ack, miss_replay, miss_rtrn_vld, wr_cl_vld, rd_ack;
  dcache_req_i_t req_i;
  dcache_req_o_t req_o;
  logic miss_req, miss_we, miss_nc, rd_req, rd_tag_only;
  logic [XLEN-1:0] miss_wdata, rd_data;
  logic [DCACHE_USER_WIDTH-1:0] miss_wuser, rd_user;
  logic [DCACHE_SET_ASSOC-1:0] miss_vld_bits, rd_vld_bits, rd_hit_oh;
  logic [PLEN-1:0] miss_paddr;
  logic [2:0] miss_size;
  logic [CACHE_ID_WIDTH-1:0] miss_id;
  logic [DCACHE_TAG_WIDTH-1:0] rd_tag;
  logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx;
  logic [DCACHE_OFFSET_WIDTH-1:0] rd_off;

  typedef struct {
    bit              chk;
    logic [XLEN-1:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t exp_e;
  int n_cmp = 0;
  int n_err = 0;

  wt_dcache_ctrl #(.RdTxId(1), .ArianeCfg(ArianeDefaultConfig)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cache_en_i(cache_en), .req_port_i(req_i),
    .req_port_o(req_o), .miss_req_o(miss_req), .miss_ack_i(miss_ack), .miss_we_o(miss_we),
    .miss_wdata_o(miss_wdata), .miss_wuser_o(miss_wuser), .miss_vld_bits_o(miss_vld_bits),
    .miss_paddr_o(miss_paddr), .miss_nc_o(miss_nc), .miss_size_o(miss_size),
    .miss_id_o(miss_id), .miss_replay_i(miss_replay), .miss_rtrn_vld_i(miss_rtrn_vld),
    .wr_cl_vld_i(wr_cl_vld), .rd_tag_o(rd_tag), .rd_idx_o(rd_idx), .rd_off_o(rd_off),
    .rd_req_o(rd_req), .rd_ack_i(rd_ack), .rd_tag_only_o(rd_tag_only), .rd_data_i(rd_data),
    .rd_user_i(rd_user), .rd_vld_bits_i(rd_vld_bits), .rd_hit_oh_i(rd_hit_oh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every rvalid must match a pending expectation, in order.
  always @(negedge clk) begin
    if (rst_ni && req_o.data_rvalid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_rvalid: got rvalid=1 with nothing pending, want none");
      end else begin
        exp_e = sb_q.pop_front();
        if (exp_e.chk && req_o.data_rdata !== exp_e.data) begin
          n_err++;
          $display("FAIL sb_rdata: got %h want %h", req_o.data_rdata, exp_e.data);
        end
      end
    end
  end

  task automatic clear_inputs();
    req_i         = '0;
    miss_ack      = 1'b0;
    miss_replay   = 1'b0;
    miss_rtrn_vld = 1'b0;
    wr_cl_vld     = 1'b0;
    rd_ack        = 1'b0;
    rd_data       = '0;
    rd_user       = '0;
    rd_vld_bits   = '0;
    rd_hit_oh     = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 of every request: present it with an immediate array ack.
  task automatic issue(input logic [11:0] idx);
    clear_inputs();
    req_i.data_req      = 1'b1;
    req_i.address_index = idx;
    req_i.data_size     = 2'd3;
    rd_ack              = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (req_o.data_gnt !== 1'b0 || req_o.data_rvalid !== 1'b0 || miss_req !== 1'b0
                 || rd_req !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got gnt=%b rv=%b mreq=%b rreq=%b want 0", req_o.data_gnt,
                        req_o.data_rvalid, miss_req, rd_req);
    end
    n_cmp++; if (miss_paddr !== '0 || miss_size !== 3'd0 || miss_vld_bits !== '0
                 || rd_tag !== '0) begin
      n_err++; $display("FAIL reset_latches: got paddr=%h size=%0d vld=%h tag=%h want 0",
                        miss_paddr, miss_size, miss_vld_bits, rd_tag);
    end
    n_cmp++; if (miss_id !== 3'd1 || miss_we !== 1'b0 || rd_tag_only !== 1'b0
                 || miss_wdata !== '0) begin
      n_err++; $display("FAIL reset_const: got id=%0d we=%b tonly=%b want 1/0/0", miss_id,
                        miss_we, rd_tag_only);
    end
  endtask

  task automatic test_hit();
    issue(12'h040);
    @(negedge clk);
    n_cmp++; if (req_o.data_gnt !== 1'b1 || rd_req !== 1'b1) begin
      n_err++; $display("FAIL hit_gnt: got gnt=%b rreq=%b want 1/1", req_o.data_gnt, rd_req);
    end
    n_cmp++; if (rd_idx !== 8'h04 || rd_off !== 4'h0) begin
      n_err++; $display("FAIL hit_idx: got idx=%h off=%h want 04/0", rd_idx, rd_off);
    end
    tick();
    clear_inputs();
    req_i.tag_valid = 1'b1; req_i.address_tag = TagC;
    rd_hit_oh = 8'b0000_0010; rd_data = 64'hDEAD;
    sb_q.push_back('{1'b1, 64'hDEAD});
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b1 || rd_tag !== TagC) begin
      n_err++; $display("FAIL hit_rvalid: got rv=%b tag=%h want 1/%h", req_o.data_rvalid, rd_tag,
                        TagC);
    end
    tick();
    clear_inputs();
  endtask

  // Request that misses; checks the miss request fields, then completes via refill.
  task automatic run_miss(input logic [DCACHE_TAG_WIDTH-1:0] tag, input logic en,
                          input logic [7:0] hit, input logic want_nc, input logic [63:0] d,
                          input string nm);
    issue(12'h040);
    cache_en = en;
    tick();
    clear_inputs();
    req_i.tag_valid = 1'b1; req_i.address_tag = tag; rd_hit_oh = hit; rd_vld_bits = 8'hA5;
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b0) begin
      n_err++; $display("FAIL %s_no_rvalid: got %b want 0", nm, req_o.data_rvalid);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (miss_req !== 1'b1 || miss_paddr !== {tag, 12'h040} || miss_nc !== want_nc) begin
      n_err++; $display("FAIL %s_req: got mreq=%b paddr=%h nc=%b want 1/%h/%b", nm, miss_req,
                        miss_paddr, miss_nc, {tag, 12'h040}, want_nc);
    end
    n_cmp++; if (miss_size !== 3'd3 || miss_vld_bits !== 8'hA5 || miss_id !== 3'd1) begin
      n_err++; $display("FAIL %s_fields: got size=%0d vld=%h id=%0d want 3/a5/1", nm, miss_size,
                        miss_vld_bits, miss_id);
    end
    tick();
    @(negedge clk);
    n_cmp++; if (miss_req !== 1'b1) begin
      n_err++; $display("FAIL %s_hold: got mreq=%b want 1", nm, miss_req);
    end
    tick();
    miss_ack = 1'b1;
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (miss_req !== 1'b0 || req_o.data_rvalid !== 1'b0) begin
      n_err++; $display("FAIL %s_wait: got mreq=%b rv=%b want 0/0", nm, miss_req,
                        req_o.data_rvalid);
    end
    repeat (4) tick();
    miss_rtrn_vld = 1'b1; rd_data = d;
    sb_q.push_back('{1'b1, d});
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b1) begin
      n_err++; $display("FAIL %s_rtrn: got rv=%b want 1", nm, req_o.data_rvalid);
    end
    tick();
    clear_inputs();
    cache_en = 1'b1;
  endtask

  task automatic test_miss();
    run_miss(TagC, 1'b1, 8'h00, 1'b0, 64'hBEEF, "miss");
    run_miss(TagC, 1'b0, 8'h01, 1'b1, 64'h5555, "nc_disabled");
    run_miss(TagIo, 1'b1, 8'h00, 1'b1, 64'h6666, "nc_region");
  endtask

  task automatic test_collision();
    issue(12'h0C4);
    tick();
    clear_inputs();
    req_i.tag_valid = 1'b1; req_i.address_tag = TagC; rd_hit_oh = 8'h02; wr_cl_vld = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b0) begin
      n_err++; $display("FAIL coll_no_rvalid: got %b want 0", req_o.data_rvalid);
    end
    tick();
    clear_inputs();
    rd_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (rd_req !== 1'b1 || rd_idx !== 8'h0C || rd_off !== 4'h4 || rd_tag !== TagC) begin
      n_err++; $display("FAIL coll_replay_req: got rreq=%b idx=%h off=%h tag=%h want 1/0c/4/%h",
                        rd_req, rd_idx, rd_off, rd_tag, TagC);
    end
    tick();
    clear_inputs();
    rd_hit_oh = 8'h02; rd_data = 64'h1234;
    sb_q.push_back('{1'b1, 64'h1234});
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b1) begin
      n_err++; $display("FAIL coll_rvalid: got %b want 1", req_o.data_rvalid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_kill();
    // Kill during compare outranks a hit and a concurrent new request.
    issue(12'h040);
    tick();
    issue(12'h080);
    req_i.kill_req = 1'b1; req_i.tag_valid = 1'b1; req_i.address_tag = TagC; rd_hit_oh = 8'h02;
    sb_q.push_back('{1'b0, '0});
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b1 || req_o.data_gnt !== 1'b0) begin
      n_err++; $display("FAIL kill_read: got rv=%b gnt=%b want 1/0", req_o.data_rvalid,
                        req_o.data_gnt);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (rd_req !== 1'b0 || req_o.data_rvalid !== 1'b0) begin
      n_err++; $display("FAIL kill_read_idle: got rreq=%b rv=%b want 0/0", rd_req,
                        req_o.data_rvalid);
    end
    // Kill while waiting for a refill.
    issue(12'h040);
    tick();
    clear_inputs();
    req_i.tag_valid = 1'b1; req_i.address_tag = TagC;
    tick();
    clear_inputs();
    miss_ack = 1'b1;
    tick();
    clear_inputs();
    tick();
    req_i.kill_req = 1'b1;
    sb_q.push_back('{1'b0, '0});
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b1) begin
      n_err++; $display("FAIL kill_wait: got rv=%b want 1", req_o.data_rvalid);
    end
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (req_o.data_rvalid !== 1'b0) begin
        n_err++; $display("FAIL kill_miss_quiet: got rv=%b want 0", req_o.data_rvalid);
      end
      tick();
    end
    miss_rtrn_vld = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b0) begin
      n_err++; $display("FAIL kill_miss_rtrn: got rv=%b want 0", req_o.data_rvalid);
    end
    tick();
    issue(12'h100);
    @(negedge clk);
    n_cmp++; if (req_o.data_gnt !== 1'b1) begin
      n_err++; $display("FAIL kill_back_idle: got gnt=%b want 1", req_o.data_gnt);
    end
    tick();
    clear_inputs();
    req_i.tag_valid = 1'b1; req_i.address_tag = TagC; rd_hit_oh = 8'h10; rd_data = 64'h7777;
    sb_q.push_back('{1'b1, 64'h7777});
    tick();
    clear_inputs();
  endtask

  task automatic test_replay();
    issue(12'h0C0);
    tick();
    clear_inputs();
    req_i.tag_valid = 1'b1; req_i.address_tag = TagC;
    tick();
    clear_inputs();
    miss_replay = 1'b1;
    @(negedge clk);
    n_cmp++; if (miss_req !== 1'b1) begin
      n_err++; $display("FAIL replay_mreq: got %b want 1", miss_req);
    end
    tick();
    clear_inputs();
    rd_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (rd_req !== 1'b1 || rd_idx !== 8'h0C || miss_req !== 1'b0) begin
      n_err++; $display("FAIL replay_rreq: got rreq=%b idx=%h mreq=%b want 1/0c/0", rd_req,
                        rd_idx, miss_req);
    end
    tick();
    clear_inputs();
    rd_hit_oh = 8'h80; rd_data = 64'hCAFE;
    sb_q.push_back('{1'b1, 64'hCAFE});
    @(negedge clk);
    n_cmp++; if (req_o.data_rvalid !== 1'b1) begin
      n_err++; $display("FAIL replay_rvalid: got %b want 1", req_o.data_rvalid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [11:0] idx;
    issue(12'h200);
    tick();
    for (int k = 1; k <= 4; k++) begin
      idx = 12'h200 + 12'(k) * 12'h040;
      if (k < 4) issue(idx);
      else clear_inputs();
      req_i.tag_valid = 1'b1; req_i.address_tag = TagC;
      rd_hit_oh = 8'h04; rd_data = 64'hB000 + 64'(k);
      sb_q.push_back('{1'b1, 64'hB000 + 64'(k)});
      @(negedge clk);
      n_cmp++; if (req_o.data_rvalid !== 1'b1 || req_o.data_gnt !== (k < 4)) begin
        n_err++; $display("FAIL b2b_%0d: got rv=%b gnt=%b want 1/%b", k, req_o.data_rvalid,
                          req_o.data_gnt, k < 4);
      end
      if (k < 4) begin
        n_cmp++; if (rd_idx !== idx[11:4]) begin
          n_err++; $display("FAIL b2b_idx_%0d: got %h want %h", k, rd_idx, idx[11:4]);
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst_ni   = 1'b0;
    cache_en = 1'b1;
    clear_inputs();
    test_reset();
    tick();
    rst_ni = 1'b1;
    tick();
    test_hit();
    test_miss();
    test_collision();
    test_kill();
    test_replay();
    test_back_to_back();
    @(negedge clk);
    n_cmp++; if (sb_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
